// File: rtl/awb_gain_est_pkg.sv
`default_nettype none
// ============================================================================
// Module  : awb_pkg (package)
// Purpose : Shared types and constants for the gray-world AWB gain estimator:
//           Bayer colour codes, unity gain and the estimator FSM state type.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package awb_pkg;

  typedef logic [1:0] color_t;

  localparam color_t RED   = 2'd0;
  localparam color_t GREEN = 2'd1;
  localparam color_t BLUE  = 2'd2;

  localparam logic [15:0] UNITY_GAIN = 16'h0100;

  // One divide slot per AVG_*/DIV_* state, then a single update cycle.
  typedef enum logic [2:0] {
    S_ACC   = 3'd0,
    S_AVG_R = 3'd1,
    S_AVG_G = 3'd2,
    S_AVG_B = 3'd3,
    S_DIV_R = 3'd4,
    S_DIV_B = 3'd5,
    S_UPD   = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/awb_gain_est_if.sv
`default_nettype none
// ============================================================================
// Module  : awb_gain_est_if (interface)
// Purpose : Bayer pixel stream tapped by the AWB estimator.
// Ports   : valid_i  pixel valid
//           color_i  0=R 1=G 2=B 3=ignored
//           value_i  pixel value (PIX_W bits)
//           last_i   last pixel of frame, qualified by valid_i
//           modport master drives the stream, modport slave receives it.
// Revision: 1.0 - initial release
// ============================================================================
interface awb_gain_est_if
  import awb_pkg::*;
#(
  parameter int PIX_W = 8
);
  logic             valid_i;
  color_t           color_i;
  logic [PIX_W-1:0] value_i;
  logic             last_i;

  modport master (output valid_i, color_i, value_i, last_i);
  modport slave  (input  valid_i, color_i, value_i, last_i);
endinterface
`default_nettype wire

// File: rtl/awb_gain_est_div.sv
`default_nettype none
// ============================================================================
// Module  : awb_div
// Purpose : W-bit unsigned restoring divider, one quotient bit per cycle.
//           start loads num/den (1 cycle), then W iterations; done pulses in
//           the cycle after the last iteration with quot valid and held
//           until the next start. den=0 yields quot = all ones.
// Ports   : clk, rst_n (sync active-low), start, num, den -> done, quot
// Revision: 1.0 - initial release
// ============================================================================
module awb_div #(
  parameter int W = 28
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         start,
  input  wire logic [W-1:0] num,
  input  wire logic [W-1:0] den,
  output logic              done,
  output logic [W-1:0]      quot
);
  localparam int IT_W = $clog2(W + 1);

  logic [W-1:0]    rem;
  logic [W-1:0]    den_q;
  logic [IT_W-1:0] iter;
  logic [W:0]      rem_sh;
  logic            take;

  // quot doubles as the dividend shift register; its MSB feeds the remainder.
  always_comb begin
    rem_sh = {rem, quot[W-1]};
    take   = (rem_sh >= {1'b0, den_q});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem   <= '0;
      den_q <= '0;
      quot  <= '0;
      iter  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem   <= '0;
        quot  <= num;
        den_q <= den;
        iter  <= IT_W'(W);
      end else if (iter != '0) begin
        rem  <= take ? W'(rem_sh - {1'b0, den_q}) : rem_sh[W-1:0];
        quot <= {quot[W-2:0], take};
        iter <= iter - IT_W'(1);
        if (iter == IT_W'(1)) done <= 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/awb_gain_est.sv
`default_nettype none
// ============================================================================
// Module  : awb_gain_est
// Purpose : Gray-world AWB estimator. Accumulates per-channel sums/counts of
//           the Bayer stream, snapshots them at frame end, then computes
//           K_c = avg_G/avg_c in Q8.8 with one shared serial divider
//           (avg_R, avg_G, avg_B, q_R, q_B) and loads K_R/K_G/K_B atomically.
// Ports   : clk, rst_n (sync active-low); pix (awb_gain_est_if.slave);
//           K_R/K_G/K_B Q8.8 gains; valid_gain_o; gain_upd_o (1-cycle);
//           busy_o; overrun_o (1-cycle, frame end dropped while busy)
// Config  : AWB_GAIN_IIR_EN - IIR smoothing of the gains (shift IIR_SHIFT)
// Revision: 1.0 - initial release
// ============================================================================
module awb_gain_est
  import awb_pkg::*;
#(
  parameter int          PIX_W    = 8,
  parameter int          CNT_W    = 20,
  parameter int          SUM_W    = 28,
  parameter logic [15:0] GAIN_MAX = 16'h0FFF
`ifdef AWB_GAIN_IIR_EN
  ,
  parameter int          IIR_SHIFT = 2
`endif
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  awb_gain_est_if.slave   pix,
  output logic [15:0]     K_R,
  output logic [15:0]     K_G,
  output logic [15:0]     K_B,
  output logic            valid_gain_o,
  output logic            gain_upd_o,
  output logic            busy_o,
  output logic            overrun_o
);
  localparam int             SLOT_W    = $clog2(SUM_W + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SUM_W);

  logic [SUM_W-1:0] sum_acc [3], sum_nxt [3], snap_sum [3];
  logic [CNT_W-1:0] cnt_acc [3], cnt_nxt [3], snap_cnt [3];
  logic [SUM_W-1:0] avg_r, avg_g, avg_b, q_r;
  logic [SUM_W-1:0] div_num, div_den, div_quot;
  logic             div_start, div_done;
  logic             frame_end, busy;
  logic [15:0]      gain_r_new, gain_b_new;
  logic [SLOT_W-1:0] slot, slot_nxt;
  state_t           state, state_nxt;

  assign frame_end = pix.valid_i & pix.last_i;
  assign busy      = (state != S_ACC);
  assign busy_o    = busy;
  assign K_G       = UNITY_GAIN;

  function automatic logic [15:0] clamp_gain(input logic [SUM_W-1:0] q);
    if (q > SUM_W'(GAIN_MAX)) return GAIN_MAX;
    return q[15:0];
  endfunction

`ifdef AWB_GAIN_IIR_EN
  function automatic logic [15:0] iir_blend(input logic [15:0] cur,
                                            input logic [15:0] q,
                                            input logic        first);
    logic signed [16:0] diff, acc;
    if (first) return q;
    diff = $signed({1'b0, q}) - $signed({1'b0, cur});
    acc  = $signed({1'b0, cur}) + (diff >>> IIR_SHIFT);
    if (acc < 0) return '0;
    if (acc > $signed({1'b0, GAIN_MAX})) return GAIN_MAX;
    return acc[15:0];
  endfunction
`endif

  // Counts saturate at all-ones; the channel then freezes for the frame.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      sum_nxt[c] = sum_acc[c];
      cnt_nxt[c] = cnt_acc[c];
      if (pix.valid_i && pix.color_i == color_t'(c) && cnt_acc[c] != '1) begin
        sum_nxt[c] = sum_acc[c] + SUM_W'(pix.value_i);
        cnt_nxt[c] = cnt_acc[c] + CNT_W'(1);
      end
    end
  end

  // The frame-end pixel goes into the snapshot; accumulation restarts with no gap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        sum_acc[c]  <= '0;
        cnt_acc[c]  <= '0;
        snap_sum[c] <= '0;
        snap_cnt[c] <= '0;
      end
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= frame_end & busy;
      for (int c = 0; c < 3; c++) begin
        if (frame_end) begin
          sum_acc[c] <= '0;
          cnt_acc[c] <= '0;
          if (!busy) begin
            snap_sum[c] <= sum_nxt[c];
            snap_cnt[c] <= cnt_nxt[c];
          end
        end else begin
          sum_acc[c] <= sum_nxt[c];
          cnt_acc[c] <= cnt_nxt[c];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_ACC;
      slot  <= '0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
    end
  end

  // Each divide state lasts SUM_W+1 cycles: load on slot 0, iterate after.
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    div_start = 1'b0;
    div_num   = '0;
    div_den   = '0;
    case (state)
      S_ACC: begin
        slot_nxt = '0;
        if (frame_end) state_nxt = S_AVG_R;
      end
      S_UPD: state_nxt = S_ACC;
      default: begin
        div_start = (slot == '0);
        slot_nxt  = (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);
        case (state)
          S_AVG_R: begin
            div_num = snap_sum[RED];
            div_den = SUM_W'(snap_cnt[RED]);
            if (slot == SLOT_LAST) state_nxt = S_AVG_G;
          end
          S_AVG_G: begin
            div_num = snap_sum[GREEN];
            div_den = SUM_W'(snap_cnt[GREEN]);
            if (slot == SLOT_LAST) state_nxt = S_AVG_B;
          end
          S_AVG_B: begin
            div_num = snap_sum[BLUE];
            div_den = SUM_W'(snap_cnt[BLUE]);
            if (slot == SLOT_LAST) state_nxt = S_DIV_R;
          end
          S_DIV_R: begin
            div_num = avg_g << 8;
            div_den = avg_r;
            if (slot == SLOT_LAST) state_nxt = S_DIV_B;
          end
          default: begin
            div_num = avg_g << 8;
            div_den = avg_b;
            if (slot == SLOT_LAST) state_nxt = S_UPD;
          end
        endcase
      end
    endcase
  end

  awb_div #(.W(SUM_W)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .num   (div_num),
    .den   (div_den),
    .done  (div_done),
    .quot  (div_quot)
  );

  // A divide completes in the first cycle of the following state, so the
  // result is filed by the state that is current when done pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      avg_r <= '0;
      avg_g <= '0;
      avg_b <= '0;
      q_r   <= '0;
    end else if (div_done) begin
      case (state)
        S_AVG_G: avg_r <= (snap_cnt[RED]   == '0) ? '0 : div_quot;
        S_AVG_B: avg_g <= (snap_cnt[GREEN] == '0) ? '0 : div_quot;
        S_DIV_R: avg_b <= (snap_cnt[BLUE]  == '0) ? '0 : div_quot;
        S_DIV_B: q_r   <= div_quot;
        default: ;
      endcase
    end
  end

  // q_B is still sitting in the divider during UPD.
  always_comb begin
    gain_r_new = (avg_g == '0 || avg_r == '0) ? UNITY_GAIN : clamp_gain(q_r);
    gain_b_new = (avg_g == '0 || avg_b == '0) ? UNITY_GAIN : clamp_gain(div_quot);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      K_R          <= UNITY_GAIN;
      K_B          <= UNITY_GAIN;
      valid_gain_o <= 1'b0;
      gain_upd_o   <= 1'b0;
    end else begin
      gain_upd_o <= 1'b0;
      if (state == S_UPD) begin
`ifdef AWB_GAIN_IIR_EN
        K_R <= iir_blend(K_R, gain_r_new, ~valid_gain_o);
        K_B <= iir_blend(K_B, gain_b_new, ~valid_gain_o);
`else
        K_R <= gain_r_new;
        K_B <= gain_b_new;
`endif
        valid_gain_o <= 1'b1;
        gain_upd_o   <= 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_awb_gain_est.sv
`default_nettype none
// ============================================================================
// Module  : tb_awb_gain_est
// Purpose : Self-checking bench for awb_gain_est. Directed RGGB frames plus
//           random frames, checked against a frame-level arithmetic model of
//           the gray-world gains (averages, Q8.8 ratio, clamp, optional IIR).
// Revision: 1.0 - initial release
// ============================================================================
module tb_awb_gain_est;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  awb_gain_est_if pix ();

  logic [15:0] K_R, K_G, K_B;
  logic        valid_gain_o, gain_upd_o, busy_o, overrun_o;

  awb_gain_est dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pix          (pix),
    .K_R          (K_R),
    .K_G          (K_G),
    .K_B          (K_B),
    .valid_gain_o (valid_gain_o),
    .gain_upd_o   (gain_upd_o),
    .busy_o       (busy_o),
    .overrun_o    (overrun_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fe       = 0;
  int n_upd    = 0;
  int upd_cyc  = -1;
  int n_ovr    = 0;

  // frame-level model state
  int m_sum [3];
  int m_cnt [3];
  int m_kr = 256;
  int m_kb = 256;
  bit m_have = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (gain_upd_o) begin
      n_upd++;
      upd_cyc = cyc;
    end
    if (overrun_o) n_ovr++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ratio_gain(int sg, int cg, int sc, int cc);
    int ag, ac, q;
    ag = (cg != 0) ? sg / cg : 0;
    ac = (cc != 0) ? sc / cc : 0;
    if (ag == 0 || ac == 0) return 256;
    q = (ag * 256) / ac;
    return (q > 4095) ? 4095 : q;
  endfunction

  function automatic int smooth(int cur, int q, bit have);
`ifdef AWB_GAIN_IIR_EN
    int r;
    if (!have) return q;
    r = cur + ((q - cur) >>> 2);
    if (r < 0) r = 0;
    if (r > 4095) r = 4095;
    return r;
`else
    return q + 0 * (cur + int'(have));
`endif
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 3; c++) begin
      m_sum[c] = 0;
      m_cnt[c] = 0;
    end
  endtask

  task automatic model_frame_end(input bit accept);
    int qr, qb;
    if (accept) begin
      qr = ratio_gain(m_sum[1], m_cnt[1], m_sum[0], m_cnt[0]);
      qb = ratio_gain(m_sum[1], m_cnt[1], m_sum[2], m_cnt[2]);
      m_kr = smooth(m_kr, qr, m_have);
      m_kb = smooth(m_kb, qb, m_have);
      m_have = 1'b1;
    end
    model_clear();
  endtask

  task automatic px(input int c, input int v, input bit l);
    logic [1:0] cc;
    logic [7:0] vv;
    cc = c[1:0];
    vv = v[7:0];
    pix.valid_i = 1'b1;
    pix.color_i = cc;
    pix.value_i = vv;
    pix.last_i  = l;
    if (c < 3 && m_cnt[c] < (1 << 20) - 1) begin
      m_sum[c] += v;
      m_cnt[c]++;
    end
    if (l) fe = cyc;
    @(posedge clk);
    #1;
    pix.valid_i = 1'b0;
    pix.last_i  = 1'b0;
  endtask

  task automatic rggb(input int r, input int g, input int b, input bit no_b);
    int c, v;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        if (y % 2 == 0) c = (x % 2 == 0) ? 0 : 1;
        else            c = (x % 2 == 0) ? 1 : 2;
        if (c == 2 && no_b) c = 3;
        v = (c == 0) ? r : (c == 1) ? g : b;
        px(c, v, (y == 3 && x == 3));
      end
    end
  endtask

  task automatic rand_frame(input int n);
    for (int i = 0; i < n; i++)
      px(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), (i == n - 1));
  endtask

  task automatic wait_upd(input string tag);
    int n0, f0;
    n0 = n_upd;
    f0 = fe;
    while (n_upd == n0 && cyc < f0 + 300) @(posedge clk);
    #1;
    check_eq({tag, "_latency"}, upd_cyc - f0, 147);
    check_eq({tag, "_K_R"}, K_R, m_kr);
    check_eq({tag, "_K_G"}, K_G, 16'h0100);
    check_eq({tag, "_K_B"}, K_B, m_kb);
    check_eq({tag, "_valid"}, valid_gain_o, 1'b1);
  endtask

  initial begin
    int n0, o0, f1;
    pix.valid_i = 1'b0;
    pix.color_i = 2'd0;
    pix.value_i = 8'd0;
    pix.last_i  = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_K_R", K_R, 16'h0100);
    check_eq("rst_K_G", K_G, 16'h0100);
    check_eq("rst_K_B", K_B, 16'h0100);
    check_eq("rst_valid", valid_gain_o, 1'b0);
    check_eq("rst_upd", gain_upd_o, 1'b0);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_ovr", overrun_o, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // flat gray frame
    rggb(100, 100, 100, 1'b0);
    check_eq("t1_busy_rise", busy_o, 1'b1);
    model_frame_end(1'b1);
    wait_upd("t1");

    rggb(50, 100, 200, 1'b0);
    model_frame_end(1'b1);
    wait_upd("t2");

    // red gain clamps
    rggb(5, 200, 200, 1'b0);
    model_frame_end(1'b1);
    wait_upd("t3");

    // no blue pixels at all
    rggb(int'($urandom_range(1, 255)), int'($urandom_range(1, 255)), 0, 1'b1);
    model_frame_end(1'b1);
    wait_upd("t4");

    // second frame end 40 cycles into the compute is dropped
    n0 = n_upd;
    o0 = n_ovr;
    rggb(60, 120, 30, 1'b0);
    f1 = fe;
    model_frame_end(1'b1);
    repeat (24) @(posedge clk);
    #1;
    rggb(200, 10, 90, 1'b0);
    model_frame_end(1'b0);
    fe = f1;
    wait_upd("t5");
    repeat (200) @(posedge clk);
    #1;
    check_eq("t5_overrun_cnt", n_ovr - o0, 1);
    check_eq("t5_upd_cnt", n_upd - n0, 1);

    for (int k = 0; k < 5; k++) begin
      rand_frame(int'($urandom_range(6, 40)));
      model_frame_end(1'b1);
      wait_upd($sformatf("rand%0d", k));
    end

    // reset in the middle of a computation
    n0 = n_upd;
    rggb(40, 90, 70, 1'b0);
    model_clear();
    while (cyc < fe + 60) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("t6_K_R", K_R, 16'h0100);
    check_eq("t6_K_B", K_B, 16'h0100);
    check_eq("t6_valid", valid_gain_o, 1'b0);
    check_eq("t6_busy", busy_o, 1'b0);
    rst_n = 1'b1;
    m_have = 1'b0;
    m_kr = 256;
    m_kb = 256;
    repeat (200) @(posedge clk);
    #1;
    check_eq("t6_no_upd", n_upd - n0, 0);
    check_eq("t6_valid_hold", valid_gain_o, 1'b0);

    // first update after reset
    rggb(50, 100, 200, 1'b0);
    model_frame_end(1'b1);
    wait_upd("t7");
    rand_frame(24);
    model_frame_end(1'b1);
    wait_upd("t8");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
